// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for divw/divwu/modw/modwu.
// Produces {remainder, quotient} with truncating signed semantics.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   div_result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dsr;
  logic             q_neg, r_neg;

  logic             accept, div_zero, sign_ovf, last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] shifted, rem_step, quo_step, rem_fix, quo_fix;
  logic [WIDTH:0]   trial;

  assign accept    = (state == IDLE) && start && !flush;
  assign div_zero  = (divisor == '0);
  assign sign_ovf  = is_signed && (dividend == MIN_NEG) && (divisor == '1);
  assign last_iter = (count == CW'(WIDTH - 1));
  assign a_mag     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag     = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Before the final shift the partial remainder is below 2^(WIDTH-1), so
  // dropping its top bit loses nothing; the extra trial bit is the borrow.
  assign shifted  = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {1'b0, dsr};
  assign rem_step = trial[WIDTH] ? shifted : trial[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign quo_fix  = q_neg ? -quo_step : quo_step;
  assign rem_fix  = r_neg ? -rem_step : rem_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (div_zero || sign_ovf) ? DONE : CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath and registered outputs; a flushed op never touches div_result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      div_result <= '0;
      count      <= '0;
      rem        <= '0;
      quo        <= '0;
      dsr        <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            rem   <= '0;
            quo   <= a_mag;
            dsr   <= b_mag;
            count <= '0;
            q_neg <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= is_signed && dividend[WIDTH-1];
            if (div_zero)      div_result <= {dividend, {WIDTH{1'b1}}};
            else if (sign_ovf) div_result <= {{WIDTH{1'b0}}, MIN_NEG};
          end
        end
        CALC: begin
          if (!flush) begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + CW'(1);
            if (last_iter) div_result <= {rem_fix, quo_fix};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: expected results are queued at start and
// popped when done pulses; also covers flush, ignored start and async reset.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst, start, is_signed, flush;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [63:0] div_result;

  int compares = 0;
  int fails = 0;
  int done_pulses = 0;
  int expected_dones = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];

  iter_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy), .done(done), .div_result(div_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_pulses++;

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, sq, sr;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    if (sgn) begin
      sa = a; sb = b;
      sq = sa / sb; sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge of cycle N+1.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input bit track, input logic [63:0] exp, input int exp_lat);
    is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
    if (track) begin
      exp_q.push_back(exp);
      lat_q.push_back(exp_lat);
      expected_dones++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int first_lat);
    int lat = first_lat;
    logic [63:0] exp;
    int exp_lat;
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    exp = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_result"}, div_result, exp);
    checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput({tag, "_idle_after"}, {62'b0, busy, done}, 64'd0);
  endtask

  task automatic randomOp(input logic sgn, input string tag);
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom >> $urandom_range(0, 31);
    applyStimulus(sgn, a, b, 1, model(sgn, a, b), (b == 0) ? 1 : 33);
    waitDone(tag, 1);
  endtask

  initial begin
    logic [63:0] prev;
    rst = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_result", div_result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic unsigned and signed division");
    applyStimulus(0, 32'd100, 32'd7, 1, {32'd2, 32'd14}, 33);
    waitDone("udiv_100_7", 1);
    applyStimulus(1, 32'hFFFF_FFF9, 32'd2, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    waitDone("sdiv_m7_2", 1);
    applyStimulus(1, 32'd7, 32'hFFFF_FFFE, 1, {32'd1, 32'hFFFF_FFFD}, 33);
    waitDone("sdiv_7_m2", 1);
    applyStimulus(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1, {32'hFFFF_FFFE, 32'd14}, 33);
    waitDone("sdiv_m100_m7", 1);
    applyStimulus(0, 32'hFFFF_FFFF, 32'h8000_0001, 1, {32'h7FFF_FFFE, 32'd1}, 33);
    waitDone("udiv_large", 1);

    $display("[TB] divide by zero and signed overflow");
    applyStimulus(0, 32'h1234_5678, 32'd0, 1, {32'h1234_5678, 32'hFFFF_FFFF}, 1);
    waitDone("udiv_zero", 1);
    applyStimulus(1, 32'h1234_5678, 32'd0, 1, {32'h1234_5678, 32'hFFFF_FFFF}, 1);
    waitDone("sdiv_zero", 1);
    applyStimulus(1, 32'h8000_0000, 32'hFFFF_FFFF, 1, {32'h0, 32'h8000_0000}, 1);
    waitDone("sdiv_ovf", 1);
    applyStimulus(0, 32'h8000_0000, 32'hFFFF_FFFF, 1, {32'h8000_0000, 32'h0}, 33);
    waitDone("udiv_ovf_operands", 1);

    $display("[TB] random operands");
    for (int i = 0; i < 3; i++) begin
      randomOp(0, "rand_unsigned");
      randomOp(1, "rand_signed");
    end

    $display("[TB] flush mid-operation");
    prev = div_result;
    applyStimulus(0, 32'd100, 32'd7, 0, 64'd0, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_result_kept", div_result, prev);
    applyStimulus(0, 32'd1000, 32'd33, 1, {32'd10, 32'd30}, 33);
    waitDone("after_flush", 1);

    $display("[TB] start while busy is ignored");
    applyStimulus(0, 32'd100, 32'd7, 1, {32'd2, 32'd14}, 33);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd0; is_signed = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("start_while_busy", 6);

    $display("[TB] start and flush together in IDLE");
    prev = div_result;
    flush = 1'b1;
    applyStimulus(0, 32'd5, 32'd0, 0, 64'd0, 0);
    flush = 1'b0;
    checkOutput("start_flush_busy", {62'b0, busy, done}, 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("start_flush_result", div_result, prev);

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(0, 32'd100, 32'd7, 0, 64'd0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("areset_busy", 64'(busy), 64'd0);
    checkOutput("areset_done", 64'(done), 64'd0);
    checkOutput("areset_result", div_result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1, 32'hFFFF_FFF9, 32'd2, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    waitDone("after_reset", 1);

    repeat (3) @(negedge clk);
    checkOutput("done_pulse_count", 64'(done_pulses), 64'(expected_dones));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
